regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (canWrite/writeReg/writeData of regmem) among NUM_REQ writeback sources, e.g. ALU result, load return and multiply/divide result.
- Uses round-robin arbitration with a valid/ready handshake per requester and a registered output stage that drives the register-file write port directly.
- Filters writes to $0 and supports a pipeline-wide hold.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register index width (32 registers).

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  requester i has a write pending.
- req_ready  output  NUM_REQ  requester i's write is accepted this cycle; one-hot or zero.
- req_addr  input  NUM_REQ*ADDR_WIDTH  destination register; slice i belongs to requester i.
- req_data  input  NUM_REQ*DATA_WIDTH  write data; slice i belongs to requester i.
- wb_hold  input  1  freeze: no grants, no writes.
- wr_en  output  1  to regmem canWrite.
- wr_addr  output  ADDR_WIDTH  to regmem writeReg.
- wr_data  output  DATA_WIDTH  to regmem writeData.
- grant_id  output  clog2(NUM_REQ)  index of the requester whose write is on wr_*.
- rd_addr1, rd_addr2  input  ADDR_WIDTH  register-file read addresses (used only with the feature).
- fwd_hit1, fwd_hit2  output  1  forward select for read port 1/2.
- fwd_data1, fwd_data2  output  DATA_WIDTH  forwarded data for read port 1/2.

Behaviour:
- Reset (synchronous, active-high) sets wr_en=0, wr_addr=0, wr_data=0, grant_id=0, rr pointer=0, fwd_hit*=0, fwd_data*=0.
  - req_ready is held 0 while reset=1.
  - A reset asserted mid-stream discards the registered write. wr_en is 0 in the cycle after reset.
- Grant is combinational within cycle N: the first i with req_valid[i]=1, scanning from pointer upward modulo NUM_REQ.
  - req_ready[i]=1 only for that i, only if wb_hold=0 and reset=0.
  - A transfer occurs when req_valid[i] & req_ready[i].
- Output stage (posedge ending cycle N):
  - On a transfer: wr_en <= (addr != 0), wr_addr/wr_data <= granted slices, grant_id <= i.
  - With no transfer: wr_en <= 0, and wr_addr/wr_data/grant_id hold their values.
- Latency:
  - Accept in cycle N; wr_en high during cycle N+1.
  - regmem commits at the end of N+1, so the value is readable in cycle N+2.
  - Sustained throughput is one write per cycle.
- Pointer update:
  - After a transfer from i, pointer <= (i+1) mod NUM_REQ.
  - With no transfer, the pointer is unchanged.
  - A requester held valid is granted within NUM_REQ cycles while wb_hold=0.
- $0 writes: the transfer is accepted (ready=1, pointer advances) but wr_en stays 0. regmem never sees a $0 write.
- wb_hold=1: all req_ready=0, the pointer is frozen, and wr_en=0 the next cycle. On release, arbitration resumes from the frozen pointer.
- Requesters must keep addr/data stable while valid and not ready. valid may drop without a transfer.
- Same-cycle requests to the same register:
  - They are serialised in round-robin order, and the later grant overwrites the earlier one.
  - Program ordering is the pipeline's responsibility.

Optional Feature:
- REGWB_FWD_EN defined:
  - fwd_hitK = wr_en & (wr_addr == rd_addrK) & (rd_addrK != 0).
  - fwd_dataK = wr_data when the hit is set, else 0. The logic is combinational.
  - This covers the cycle where a write is on the port but not yet in regmem.
- REGWB_FWD_EN undefined: fwd_hit* are tied to 0, fwd_data* are tied to 0 and rd_addr* are unused. The interface is identical in both builds.

Decomposition:
- Package regwb_pkg holds:
  - the DATA_WIDTH and ADDR_WIDTH defaults;
  - REG_ZERO=5'd0 and REG_RA=5'd31;
  - a grant-index width function, clog2.
- One sub-module, rr_arbiter: purely combinational, inputs req and pointer, outputs one-hot grant, grant index and any_grant. Pointer state stays in the parent.

Test Plan:
- Reset, then only req 0 valid with addr=8, data=0xDEADBEEF → ready[0] in cycle 1; wr_en=1, wr_addr=8, wr_data=0xDEADBEEF in cycle 2; regmem reads 0xDEADBEEF at $8 in cycle 3.
- All 3 requests held valid for 6 cycles (addrs 1/2/3) → grant order 0,1,2,0,1,2 and wr_en high every cycle.
- req 1 valid with addr=0, data=0x55 → ready[1]=1, pointer advances, wr_en=0 and $0 reads 0.
- wb_hold=1 for 3 cycles while reqs 0 and 2 are valid (pointer=2) → no ready, wr_en=0; after release req 2 is granted first, then req 0.
- Reset pulsed the cycle after accepting addr=4 → wr_en=0 next cycle, all regs read 0 and pointer=0.
- REGWB_FWD_EN defined: write addr=9, data=0x1234 on the port with rd_addr1=9, rd_addr2=0 → fwd_hit1=1, fwd_data1=0x1234, fwd_hit2=0.
- REGWB_FWD_EN undefined: same stimulus → both fwd_hit outputs are 0.

Source files
------------

// File: rtl/regwb_pkg.sv
// rtl/regwb_pkg.sv - shared constants and helpers for the register-file writeback arbiter
package regwb_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Width of an index that can name n items; never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a caller-held pointer
module rr_arbiter
  import regwb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  // Scan from ptr upward modulo N and take the first requester found.
  always_comb begin
    logic [N-1:0] req_rot;
    int           idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    req_rot   = '0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx     = (int'(ptr) + k) % N;
      req_rot = req >> idx;
      if (!any_grant && req_rot[0]) begin
        any_grant = 1'b1;
        grant     = {{(N-1){1'b0}}, 1'b1} << idx;
        grant_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin share of the regmem write port; optional forwarding under REGWB_FWD_EN
module regfile_wb_arbiter
  import regwb_pkg::*;
#(
  parameter  int NUM_REQ    = 3,
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int ADDR_WIDTH = ADDR_WIDTH_DEF,
  localparam int IW         = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          wb_hold,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [IW-1:0]                 grant_id,
  input  logic [ADDR_WIDTH-1:0]         rd_addr1,
  input  logic [ADDR_WIDTH-1:0]         rd_addr2,
  output logic                          fwd_hit1,
  output logic                          fwd_hit2,
  output logic [DATA_WIDTH-1:0]         fwd_data1,
  output logic [DATA_WIDTH-1:0]         fwd_data2
);

  logic [IW-1:0]         ptr_q, ptr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [IW-1:0]         grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  any_gnt;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .any_grant (any_gnt)
  );

  // Hold and reset both mask the grant; a masked grant is not a transfer.
  always_comb begin
    req_ready = (reset || wb_hold) ? '0 : gnt;
    transfer  = any_gnt && !reset && !wb_hold;
    sel_addr  = ADDR_WIDTH'(req_addr >> (int'(gnt_idx) * ADDR_WIDTH));
    sel_data  = DATA_WIDTH'(req_data >> (int'(gnt_idx) * DATA_WIDTH));
  end

  // Next state: capture the winner; $0 targets are consumed without a write strobe.
  always_comb begin
    ptr_d      = ptr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    grant_id_d = grant_id_q;
    if (transfer) begin
      wr_en_d    = (sel_addr != ADDR_WIDTH'(REG_ZERO));
      wr_addr_d  = sel_addr;
      wr_data_d  = sel_data;
      grant_id_d = gnt_idx;
      ptr_d      = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Registered output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign grant_id = grant_id_q;

`ifdef REGWB_FWD_EN
  // Bypass the write sitting on the port before regmem has committed it.
  always_comb begin
    fwd_hit1  = wr_en_q && (wr_addr_q == rd_addr1) && (rd_addr1 != '0);
    fwd_hit2  = wr_en_q && (wr_addr_q == rd_addr2) && (rd_addr2 != '0);
    fwd_data1 = fwd_hit1 ? wr_data_q : '0;
    fwd_data2 = fwd_hit2 ? wr_data_q : '0;
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_addr1, rd_addr2};

  // Forwarding disabled: outputs tied off, interface unchanged.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic           clk;
  logic           reset;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic           wb_hold;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic [1:0]     grant_id;
  logic [AW-1:0]  rd_addr1, rd_addr2;
  logic           fwd_hit1, fwd_hit2;
  logic [DW-1:0]  fwd_data1, fwd_data2;

  int n_vec = 0;
  int n_err = 0;

`ifdef REGWB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wb_hold   (wb_hold),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model fed by the write port.
  logic [DW-1:0] rf [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    wb_hold = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
    tick();
    tick();

    // Reset state and ready masked during reset.
    req_valid = 3'b111;
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_wr_en", 64'(wr_en), 64'h0);
    chk("rst_wr_addr", 64'(wr_addr), 64'h0);
    chk("rst_wr_data", 64'(wr_data), 64'h0);
    chk("rst_grant_id", 64'(grant_id), 64'h0);
    chk("rst_fwd_hit1", 64'(fwd_hit1), 64'h0);
    chk("rst_fwd_data2", 64'(fwd_data2), 64'h0);
    req_valid = '0;
    reset = 1'b0;

    // Single write to $8, visible in regmem two cycles after accept.
    set_req(0, 1'b1, 5'd8, 32'hDEADBEEF);
    #1;
    chk("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    chk("t1_wr_en", 64'(wr_en), 64'h1);
    chk("t1_wr_addr", 64'(wr_addr), 64'd8);
    chk("t1_wr_data", 64'(wr_data), 64'hDEADBEEF);
    chk("t1_grant_id", 64'(grant_id), 64'h0);
    tick();
    chk("t1_wr_en_off", 64'(wr_en), 64'h0);
    chk("t1_rf8", 64'(rf[8]), 64'hDEADBEEF);

    // Restart pointer at 0, then sustained round-robin with all three valid.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 1), 32'h100 + 32'(i));
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t2_ready_%0d", k), 64'(req_ready), 64'(1 << (k % 3)));
      tick();
      chk($sformatf("t2_wr_en_%0d", k), 64'(wr_en), 64'h1);
      chk($sformatf("t2_gid_%0d", k), 64'(grant_id), 64'(k % 3));
      chk($sformatf("t2_addr_%0d", k), 64'(wr_addr), 64'((k % 3) + 1));
      chk($sformatf("t2_data_%0d", k), 64'(wr_data), 64'(32'h100 + 32'(k % 3)));
    end
    req_valid = '0;
    tick();
    chk("t2_wr_en_idle", 64'(wr_en), 64'h0);
    chk("t2_rf1", 64'(rf[1]), 64'h100);
    chk("t2_rf2", 64'(rf[2]), 64'h101);
    chk("t2_rf3", 64'(rf[3]), 64'h102);

    // $0 write: accepted, no strobe. Pointer 0 -> granted 1 -> pointer 2.
    set_req(1, 1'b1, 5'd0, 32'h55);
    #1;
    chk("t3_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    chk("t3_wr_en", 64'(wr_en), 64'h0);
    chk("t3_grant_id", 64'(grant_id), 64'h1);

    // Hold for three cycles with reqs 0 and 2 valid; pointer sits at 2.
    wb_hold = 1'b1;
    set_req(0, 1'b1, 5'd10, 32'hA0);
    set_req(2, 1'b1, 5'd12, 32'hC2);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t4_hold_ready_%0d", k), 64'(req_ready), 64'h0);
      tick();
      chk($sformatf("t4_hold_wr_en_%0d", k), 64'(wr_en), 64'h0);
    end
    chk("t4_rf0", 64'(rf[0]), 64'h0);
    wb_hold = 1'b0;
    #1;
    chk("t4_rel_ready2", 64'(req_ready), 64'h4);
    tick();
    req_valid[2] = 1'b0;
    chk("t4_rel_gid2", 64'(grant_id), 64'h2);
    chk("t4_rel_addr12", 64'(wr_addr), 64'd12);
    chk("t4_rel_wr_en", 64'(wr_en), 64'h1);
    #1;
    chk("t4_rel_ready0", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    chk("t4_rel_gid0", 64'(grant_id), 64'h0);
    chk("t4_rel_data", 64'(wr_data), 64'hA0);

    // Accept $4 from req 1, then reset the following cycle.
    set_req(1, 1'b1, 5'd4, 32'h44);
    #1;
    chk("t5_ready", 64'(req_ready), 64'h2);
    tick();
    chk("t5_wr_en", 64'(wr_en), 64'h1);
    reset = 1'b1;
    #1;
    chk("t5_ready_in_reset", 64'(req_ready), 64'h0);
    tick();
    req_valid = '0;
    reset = 1'b0;
    chk("t5_wr_en_after", 64'(wr_en), 64'h0);
    chk("t5_wr_addr_after", 64'(wr_addr), 64'h0);
    chk("t5_gid_after", 64'(grant_id), 64'h0);
    chk("t5_rf4", 64'(rf[4]), 64'h0);
    chk("t5_rf8", 64'(rf[8]), 64'h0);
    req_valid = 3'b111;
    #1;
    chk("t5_ptr0", 64'(req_ready), 64'h1);
    req_valid = '0;

    // Forwarding of the write on the port.
    set_req(0, 1'b1, 5'd9, 32'h1234);
    rd_addr1 = 5'd9;
    rd_addr2 = 5'd0;
    #1;
    chk("t6_hit1_pre", 64'(fwd_hit1), 64'h0);
    tick();
    req_valid = '0;
    chk("t6_wr_en", 64'(wr_en), 64'h1);
    chk("t6_hit1", 64'(fwd_hit1), 64'(FWD));
    chk("t6_data1", 64'(fwd_data1), FWD ? 64'h1234 : 64'h0);
    chk("t6_hit2", 64'(fwd_hit2), 64'h0);
    chk("t6_data2", 64'(fwd_data2), 64'h0);
    rd_addr1 = 5'd7;
    #1;
    chk("t6_miss1", 64'(fwd_hit1), 64'h0);
    tick();
    chk("t6_rf9", 64'(rf[9]), 64'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
